genius_round_ctrl: RTL and testbench

- Round sequencer for the Genius game datapath.
- Starts a game and commands the datapath to latch a new random sequence.
- Plays back the first `round` sequence elements with fixed on/off timing, then opens a timed user-entry window in which each `enter` rise is checked against `match`.
- Advances the round, or ends the game in win/lose.
- Sits beside the datapath and the top-level switch inputs; replaces ad-hoc enable sequencing with counted, timed phases.

---
 rtl/genius_pkg.sv | 35 +++
 rtl/genius_round_ctrl_if.sv | 45 ++++
 rtl/rise_det.sv | 34 +++
 rtl/genius_round_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_genius_round_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/genius_pkg.sv
// Shared definitions for the Genius round sequencer.
//
// Contents:
//   - 3-bit FSM state codes, kept as plain localparams so they stay
//     compatible with existing netlists and debug scripts.
//   - Default parameter values for a 50 MHz board clock.
//   - is_timed(): true for the states in which the phase timer runs.
package genius_pkg;

  // FSM state encoding.
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD      = 3'd1;
  localparam logic [2:0] SHOW      = 3'd2;
  localparam logic [2:0] GAP       = 3'd3;
  localparam logic [2:0] WAIT_USER = 3'd4;
  localparam logic [2:0] NEXT      = 3'd5;
  localparam logic [2:0] WIN       = 3'd6;
  localparam logic [2:0] LOSE      = 3'd7;

  // Defaults for the 50 MHz board build.
  localparam int DEF_MAX_ROUNDS = 16;
  localparam int DEF_IDXW       = 4;           // clog2(DEF_MAX_ROUNDS)
  localparam int DEF_RW         = 5;           // clog2(DEF_MAX_ROUNDS + 1)
  localparam int DEF_SHOW_TICKS = 50_000_000;  // 1 s element display
  localparam int DEF_GAP_TICKS  = 12_500_000;  // 250 ms blank between elements
  localparam int DEF_USER_TICKS = 250_000_000; // 5 s per user entry
  localparam int DEF_TW         = 28;          // holds DEF_USER_TICKS

  // The phase timer only counts in the three timed phases; everywhere
  // else it sits at zero.
  function automatic logic is_timed(input logic [2:0] s);
    return (s == SHOW) || (s == GAP) || (s == WAIT_USER);
  endfunction

endpackage

// File: rtl/genius_round_ctrl_if.sv
// Control bundle between the round sequencer and the rest of the Genius
// game (switches and datapath).
//
// Signals:
//   start, enter  level switches (rising edge is the event)
//   match         datapath compare result for element seq_idx
//   load_seq      one-cycle pulse: datapath latches a new random sequence
//   seq_idx       element address into the datapath
//   show          datapath displays element seq_idx
//   user_phase    user entry window open
//   round         current round length (0 when idle)
//   win, lose     held game result
//   timeout       lose was caused by an entry timeout
//
// Modports:
//   master  the sequencer (genius_round_ctrl)
//   slave   the switch/datapath side
interface genius_round_ctrl_if #(
  parameter int IDXW = 4,
  parameter int RW   = 5
);

  logic            start;
  logic            enter;
  logic            match;
  logic            load_seq;
  logic [IDXW-1:0] seq_idx;
  logic            show;
  logic            user_phase;
  logic [RW-1:0]   round;
  logic            win;
  logic            lose;
  logic            timeout;

  modport master (
    input  start, enter, match,
    output load_seq, seq_idx, show, user_phase, round, win, lose, timeout
  );

  modport slave (
    output start, enter, match,
    input  load_seq, seq_idx, show, user_phase, round, win, lose, timeout
  );

endinterface

// File: rtl/rise_det.sv
// Single-flop rising-edge detector for a level input.
//
// Ports:
//   clk    clock
//   rst    asynchronous, active-high reset
//   d      level input
//   rise   high for the one cycle in which d is 1 and was 0 last cycle
//
// RST_VAL sets the remembered previous level after reset. Using 1 means a
// switch that is already high when reset releases is not taken as a rise.
module rise_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= RST_VAL;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/genius_round_ctrl.sv
// Round sequencer for the Genius game datapath.
//
// A start rise begins a game: the datapath is told to latch a new random
// sequence, then the first `round` elements are played back (SHOW_TICKS on,
// GAP_TICKS off each), then a user window opens in which each enter rise is
// checked against `match`. A full correct round advances to the next one
// (or to WIN after MAX_ROUNDS); a wrong entry or an entry timeout ends the
// game in LOSE.
//
// Ports:
//   CLOCK   system clock
//   reset   asynchronous, active-high reset
//   bus     genius_round_ctrl_if.master (switch inputs, match, all outputs)
//
// All outputs are registered and decoded from the next state, so each one
// is already correct in the first cycle of the state it belongs to.
module genius_round_ctrl
  import genius_pkg::*;
#(
  parameter int MAX_ROUNDS = DEF_MAX_ROUNDS,
  parameter int IDXW       = DEF_IDXW,
  parameter int RW         = DEF_RW,
  parameter int SHOW_TICKS = DEF_SHOW_TICKS,
  parameter int GAP_TICKS  = DEF_GAP_TICKS,
  parameter int USER_TICKS = DEF_USER_TICKS,
  parameter int TW         = DEF_TW
) (
  input  logic                 CLOCK,
  input  logic                 reset,
  genius_round_ctrl_if.master  bus
);

  // Terminal timer values: a phase ends on its last cycle, so it lasts
  // exactly TICKS cycles counting from the cleared value 0.
  localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);
  localparam logic [TW-1:0] USER_LAST = TW'(USER_TICKS - 1);
  localparam logic [RW-1:0] ROUND_MAX = RW'(MAX_ROUNDS);

  // ---------------------------------------------------------------------
  // Switch edge detection. Rises in states that do not look at them are
  // simply dropped; nothing is queued.
  // ---------------------------------------------------------------------
  logic rise_start;
  logic rise_enter;

  rise_det #(.RST_VAL(1'b1)) u_start_rise (
    .clk  (CLOCK),
    .rst  (reset),
    .d    (bus.start),
    .rise (rise_start)
  );

  rise_det #(.RST_VAL(1'b1)) u_enter_rise (
    .clk  (CLOCK),
    .rst  (reset),
    .d    (bus.enter),
    .rise (rise_enter)
  );

  // ---------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------
  logic [2:0]      state_q;
  logic [2:0]      state_next;
  logic [TW-1:0]   timer_q;
  logic [RW-1:0]   round_q;
  logic [RW-1:0]   round_next;
  logic [IDXW-1:0] seq_idx_q;
  logic [IDXW-1:0] seq_idx_next;
  logic            timer_clr;
  logic            timeout_hit;

  logic            load_seq_q;
  logic            show_q;
  logic            user_phase_q;
  logic            win_q;
  logic            lose_q;
  logic            timeout_q;

  // The element currently addressed is the last one of this round.
  logic last_elem;
  assign last_elem = (RW'(seq_idx_q) == (round_q - RW'(1)));

  // Next-state and counter-update decode. Counter updates are attached to
  // the transition that causes them, so round/seq_idx are already correct
  // in the first cycle of LOAD, SHOW, WAIT_USER and NEXT.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    state_next   = state_q;
    round_next   = round_q;
    seq_idx_next = seq_idx_q;
    timer_clr    = 1'b0;
    timeout_hit  = 1'b0;

    case (state_q)
      IDLE, WIN, LOSE: begin
        // WIN/LOSE keep round and seq_idx for display until restarted.
        if (rise_start) begin
          state_next   = LOAD;
          round_next   = RW'(1);
          seq_idx_next = '0;
        end
      end

      LOAD: begin
        state_next = SHOW;
      end

      SHOW: begin
        if (timer_q == SHOW_LAST) begin
          state_next = GAP;
        end
      end

      GAP: begin
        if (timer_q == GAP_LAST) begin
          if (last_elem) begin
            state_next   = WAIT_USER;
            seq_idx_next = '0;
          end else begin
            state_next   = SHOW;
            seq_idx_next = seq_idx_q + IDXW'(1);
          end
        end
      end

      WAIT_USER: begin
        // An entry on the terminal cycle takes priority over the timeout.
        if (rise_enter) begin
          if (!bus.match) begin
            state_next = LOSE;
          end else if (!last_elem) begin
            seq_idx_next = seq_idx_q + IDXW'(1);
            timer_clr    = 1'b1;
          end else if (round_q == ROUND_MAX) begin
            state_next = WIN;
          end else begin
            // Round length grows on the way into NEXT; round never wraps
            // because WIN is taken at ROUND_MAX instead.
            state_next   = NEXT;
            round_next   = round_q + RW'(1);
            seq_idx_next = '0;
          end
        end else if (timer_q == USER_LAST) begin
          state_next  = LOSE;
          timeout_hit = 1'b1;
        end
      end

      NEXT: begin
        state_next = SHOW;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      round_q      <= '0;
      seq_idx_q    <= '0;
      load_seq_q   <= 1'b0;
      show_q       <= 1'b0;
      user_phase_q <= 1'b0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q   <= state_next;
      round_q   <= round_next;
      seq_idx_q <= seq_idx_next;

      // Timer restarts on every state entry and on each accepted entry,
      // and only advances in the timed phases.
      if ((state_next != state_q) || timer_clr) begin
        timer_q <= '0;
      end else if (is_timed(state_q)) begin
        timer_q <= timer_q + TW'(1);
      end

      load_seq_q   <= (state_next == LOAD);
      show_q       <= (state_next == SHOW);
      user_phase_q <= (state_next == WAIT_USER);
      win_q        <= (state_next == WIN);
      lose_q       <= (state_next == LOSE);

      // timeout is a sticky qualifier of lose, cleared when a new game loads.
      if (state_next == LOAD) begin
        timeout_q <= 1'b0;
      end else if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.load_seq   = load_seq_q;
  assign bus.seq_idx    = seq_idx_q;
  assign bus.show       = show_q;
  assign bus.user_phase = user_phase_q;
  assign bus.round      = round_q;
  assign bus.win        = win_q;
  assign bus.lose       = lose_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_genius_round_ctrl.sv
// Self-checking bench for genius_round_ctrl with a shrunken configuration
// (3 rounds, 4 show / 2 gap / 10 user ticks). Outputs are sampled and
// inputs driven on the falling clock edge. Expected behaviour comes from a
// game-level model: playback is a nested loop over round/element/tick, and
// each user window's outcome is predicted from the list of entry delays and
// match bits.
module tb_genius_round_ctrl;

  localparam int MAX_ROUNDS = 3;
  localparam int IDXW       = 2;
  localparam int RW         = 2;
  localparam int SHOW_TICKS = 4;
  localparam int GAP_TICKS  = 2;
  localparam int USER_TICKS = 10;
  localparam int TW         = 8;

  localparam int OW = 6 + RW + IDXW;
  // Compare only the six control flags (used where round/seq_idx are not
  // pinned down, i.e. the one NEXT cycle).
  localparam logic [OW-1:0] CTRL_MASK = {6'b111111, {(RW + IDXW){1'b0}}};

  typedef enum int {O_NEXT, O_WIN, O_LOSE, O_TIMEOUT} outcome_e;
  typedef int delay_t [MAX_ROUNDS];

  logic CLOCK;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  genius_round_ctrl_if #(.IDXW(IDXW), .RW(RW)) bus ();

  genius_round_ctrl #(
    .MAX_ROUNDS (MAX_ROUNDS),
    .IDXW       (IDXW),
    .RW         (RW),
    .SHOW_TICKS (SHOW_TICKS),
    .GAP_TICKS  (GAP_TICKS),
    .USER_TICKS (USER_TICKS),
    .TW         (TW)
  ) dut (
    .CLOCK (CLOCK),
    .reset (reset),
    .bus   (bus.master)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion by %0t, want summary before it", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------
  // Helpers (no checking in here)
  // ---------------------------------------------------------------------
  task automatic step();
    @(negedge CLOCK);
  endtask

  // {load_seq, show, user_phase, win, lose, timeout, round, seq_idx}
  function automatic logic [OW-1:0] observed();
    return {bus.load_seq, bus.show, bus.user_phase, bus.win, bus.lose,
            bus.timeout, bus.round, bus.seq_idx};
  endfunction

  function automatic logic [OW-1:0] expect_vec(input bit ld, input bit sh,
                                               input bit up, input bit w,
                                               input bit l, input bit to,
                                               input int rnd, input int idx);
    return {ld, sh, up, w, l, to, RW'(rnd), IDXW'(idx)};
  endfunction

  // Game-rule model of one user window: entries are taken in order; an
  // entry whose delay reaches USER_TICKS never happens (timeout), a match=0
  // entry loses, and a round fully matched goes to WIN or NEXT.
  function automatic outcome_e predict(input int r, input delay_t d,
                                       input logic [MAX_ROUNDS-1:0] m,
                                       output int at);
    at = r - 1;
    for (int i = 0; i < r; i++) begin
      if (d[i] >= USER_TICKS) begin
        at = i;
        return O_TIMEOUT;
      end
      if (!m[i]) begin
        at = i;
        return O_LOSE;
      end
    end
    return (r == MAX_ROUNDS) ? O_WIN : O_NEXT;
  endfunction

  // ---------------------------------------------------------------------
  // Scenario building blocks
  // ---------------------------------------------------------------------

  // From any idle/ended state: produce a start rise and check the LOAD cycle.
  task automatic start_game();
    logic [OW-1:0] want;
    bus.start = 1'b0;
    bus.enter = 1'b0;
    step();
    bus.start = 1'b1;
    step();
    want = expect_vec(1, 0, 0, 0, 0, 0, 1, 0);
    n_checks++;
    if (observed() !== want) begin
      n_fail++;
      $display("FAIL load_cycle: got %b want %b at %0t", observed(), want, $time);
    end
  endtask

  // Current sample is the LOAD or NEXT cycle. Checks the full playback of
  // round r and steps into the first cycle of the user window. With pokes,
  // enter/start toggle randomly (both must be ignored); hold_enter leaves
  // enter high as the window opens.
  task automatic check_playback(input int r, input bit pokes, input bit hold_enter);
    logic [OW-1:0] want;
    for (int k = 0; k < r; k++) begin
      for (int s = 0; s < SHOW_TICKS; s++) begin
        if (pokes) begin
          bus.enter = 1'($urandom);
          bus.start = 1'($urandom);
        end
        bus.match = 1'($urandom);
        step();
        want = expect_vec(0, 1, 0, 0, 0, 0, r, k);
        n_checks++;
        if (observed() !== want) begin
          n_fail++;
          $display("FAIL playback_show r=%0d k=%0d s=%0d: got %b want %b",
                   r, k, s, observed(), want);
        end
      end
      for (int g = 0; g < GAP_TICKS; g++) begin
        if (pokes) begin
          bus.enter = 1'($urandom);
          bus.start = 1'($urandom);
        end
        bus.match = 1'($urandom);
        step();
        want = expect_vec(0, 0, 0, 0, 0, 0, r, k);
        n_checks++;
        if (observed() !== want) begin
          n_fail++;
          $display("FAIL playback_gap r=%0d k=%0d g=%0d: got %b want %b",
                   r, k, g, observed(), want);
        end
      end
    end
    bus.enter = hold_enter;
    step();
  endtask

  // Current sample is the first window cycle of round r. Drives entry i
  // d[i] cycles after the window (re)opens, with match m[i], and checks
  // every window cycle plus the resulting outcome.
  task automatic run_window(input int r, input delay_t d,
                            input logic [MAX_ROUNDS-1:0] m, input bit hold,
                            output outcome_e oc);
    int            at;
    int            t;
    bit            done;
    logic [OW-1:0] want;
    oc = predict(r, d, m, at);
    for (int i = 0; i <= at; i++) begin
      t    = 0;
      done = 1'b0;
      while (!done) begin
        want = expect_vec(0, 0, 1, 0, 0, 0, r, i);
        n_checks++;
        if (observed() !== want) begin
          n_fail++;
          $display("FAIL window r=%0d i=%0d t=%0d: got %b want %b",
                   r, i, t, observed(), want);
        end
        if (t == d[i]) begin
          bus.enter = 1'b1;
          bus.match = m[i];
          step();
          bus.enter = 1'b0;
          bus.match = 1'($urandom);
          done = 1'b1;
        end else if (t == USER_TICKS - 1) begin
          step();
          done = 1'b1;
        end else begin
          if (hold && i == 0) begin
            // Held-high enter with match=0: accepting it would lose.
            bus.match = 1'b0;
            bus.enter = (t == d[i] - 1) ? 1'b0 : 1'b1;
          end else begin
            bus.match = 1'($urandom);
          end
          step();
          t++;
        end
      end
    end

    if (oc == O_NEXT) begin
      want = expect_vec(0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if ((observed() & CTRL_MASK) !== want) begin
        n_fail++;
        $display("FAIL next_cycle r=%0d: got %b want %b (flags)", r,
                 observed() & CTRL_MASK, want);
      end
    end else begin
      case (oc)
        O_WIN:   want = expect_vec(0, 0, 0, 1, 0, 0, r, r - 1);
        O_LOSE:  want = expect_vec(0, 0, 0, 0, 1, 0, r, at);
        default: want = expect_vec(0, 0, 0, 0, 1, 1, r, at);
      endcase
      for (int h = 0; h < 2; h++) begin
        n_checks++;
        if (observed() !== want) begin
          n_fail++;
          $display("FAIL game_end r=%0d outcome=%s hold=%0d: got %b want %b",
                   r, oc.name(), h, observed(), want);
        end
        if (h == 0) step();
      end
    end
  endtask

  // ---------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------

  // Reset with start held high; stay idle; first start rise; round 1 playback.
  task automatic test_reset();
    logic [OW-1:0] want;
    want = '0;
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.enter = 1'b0;
    bus.match = 1'b0;
    step();
    step();
    n_checks++;
    if (observed() !== want) begin
      n_fail++;
      $display("FAIL reset_state: got %b want %b", observed(), want);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (observed() !== want) begin
        n_fail++;
        $display("FAIL idle_start_held cyc=%0d: got %b want %b", i, observed(), want);
      end
    end
    start_game();
    check_playback(1, 1'b0, 1'b0);
  endtask

  // Round 1 window with no entry at all.
  task automatic test_timeout();
    outcome_e oc;
    delay_t   d;
    d = '{USER_TICKS, 1, 1};
    run_window(1, d, 3'b111, 1'b0, oc);
  endtask

  // Restart from LOSE; entry on the terminal cycle; wrong first entry in round 2.
  task automatic test_terminal_and_wrong();
    outcome_e oc;
    delay_t   d;
    start_game();
    check_playback(1, 1'b0, 1'b0);
    d = '{USER_TICKS - 1, 1, 1};
    run_window(1, d, 3'b111, 1'b0, oc);
    check_playback(2, 1'b0, 1'b0);
    d = '{3, 3, 3};
    run_window(2, d, 3'b110, 1'b0, oc);
  endtask

  task automatic test_perfect_game();
    outcome_e oc;
    delay_t   d;
    start_game();
    for (int r = 1; r <= MAX_ROUNDS; r++) begin
      check_playback(r, 1'b1, 1'b0);
      for (int i = 0; i < MAX_ROUNDS; i++) d[i] = $urandom_range(1, USER_TICKS - 1);
      run_window(r, d, 3'b111, 1'b0, oc);
    end
  endtask

  // Enter held high into the window, then a proper rise; loss on entry 2.
  task automatic test_enter_edges();
    outcome_e oc;
    delay_t   d;
    start_game();
    check_playback(1, 1'b1, 1'b1);
    d = '{4, 1, 1};
    run_window(1, d, 3'b111, 1'b1, oc);
    check_playback(2, 1'b1, 1'b0);
    d = '{2, 5, 1};
    run_window(2, d, 3'b101, 1'b0, oc);
  endtask

  // Asynchronous reset in the middle of a round-2 gap.
  task automatic test_reset_mid_gap();
    outcome_e      oc;
    delay_t        d;
    logic [OW-1:0] want;
    start_game();
    check_playback(1, 1'b0, 1'b0);
    d = '{1, 1, 1};
    run_window(1, d, 3'b111, 1'b0, oc);
    for (int s = 0; s < SHOW_TICKS; s++) step();
    step();
    want = expect_vec(0, 0, 0, 0, 0, 0, 2, 0);
    n_checks++;
    if (observed() !== want) begin
      n_fail++;
      $display("FAIL pre_reset_gap: got %b want %b", observed(), want);
    end
    #2 reset = 1'b1;
    #1;
    want = '0;
    n_checks++;
    if (observed() !== want) begin
      n_fail++;
      $display("FAIL async_reset_mid_gap: got %b want %b", observed(), want);
    end
    step();
    reset = 1'b0;
    step();
    n_checks++;
    if (observed() !== want) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b want %b", observed(), want);
    end
  endtask

  task automatic test_random_games();
    outcome_e oc;
    delay_t   d;
    logic [MAX_ROUNDS-1:0] m;
    bit       hold;
    int       r;
    for (int g = 0; g < 8; g++) begin
      start_game();
      r  = 1;
      oc = O_NEXT;
      while (oc == O_NEXT) begin
        hold = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < MAX_ROUNDS; i++) begin
          d[i] = ($urandom_range(0, 11) == 0) ? USER_TICKS
                                               : $urandom_range(1, USER_TICKS - 1);
          m[i] = ($urandom_range(0, 7) != 0);
        end
        check_playback(r, 1'b1, hold);
        run_window(r, d, m, hold, oc);
        r++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_terminal_and_wrong();
    test_perfect_game();
    test_enter_edges();
    test_reset_mid_gap();
    test_random_games();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
